// File: rtl/sram_word_controller.sv
// sram_word_controller: sequences one 32-bit CPU access as two 16-bit accesses to an async SRAM
//   clk, rst (async, active-low)      clock and reset
//   wr_en, rd_en, address, write_data MEM-stage request; store wins over load
//   read_data, ready                  load result and completion/no-stall flag
//   sram_addr, sram_dq_out/in/oe      half-word address and data bus
//   sram_we_n                         write strobe, low for all but the last cycle of a write half
module sram_word_controller #(
   parameter int ADDR_W      = 18,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [31:0]       address,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   output logic              ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_dq_out,
   input  logic [15:0]       sram_dq_in,
   output logic              sram_dq_oe,
   output logic              sram_we_n
);
   typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;
   state_t state, nxt;
   logic [3:0] cnt, nxt_cnt;
   logic [ADDR_W-2:0] word, word_q;
   logic [31:0] wdat, wdata_q;
   logic [15:0] lo;
   logic last, nxt_wr, nxt_hi, nxt_half;
   assign last = cnt == 4'(WAIT_CYCLES);
   always_comb begin
      case (state)
         IDLE:    nxt = wr_en ? WR_LO : rd_en ? RD_LO : IDLE;
         WR_LO:   nxt = last ? WR_HI : WR_LO;
         WR_HI:   nxt = last ? DONE : WR_HI;
         RD_LO:   nxt = last ? RD_HI : RD_LO;
         RD_HI:   nxt = last ? DONE : RD_HI;
         default: nxt = IDLE;
      endcase
   end
   // Outputs are registered, so the first half's address/data must come straight from the inputs on the accepting edge.
   assign word     = state == IDLE ? (ADDR_W-1)'((address - 32'(BASE_ADDR)) >> 2) : word_q;
   assign wdat     = state == IDLE ? write_data : wdata_q;
   assign nxt_cnt  = (nxt != state || state == IDLE) ? 4'd0 : cnt + 4'd1;
   assign nxt_wr   = nxt == WR_LO || nxt == WR_HI;
   assign nxt_hi   = nxt == WR_HI || nxt == RD_HI;
   assign nxt_half = nxt_wr || nxt == RD_LO || nxt == RD_HI;
   assign ready    = (state == IDLE && !wr_en && !rd_en) || state == DONE;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         word_q      <= '0;
         wdata_q     <= '0;
         lo          <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         state <= nxt;
         cnt   <= nxt_cnt;
         if (state == IDLE) begin
            word_q  <= word;
            wdata_q <= write_data;
         end
         if (nxt_half) sram_addr <= {word, nxt_hi};
         if (nxt_wr) sram_dq_out <= nxt_hi ? wdat[31:16] : wdat[15:0];
         sram_dq_oe <= nxt_wr;
         // The last cycle of each write half keeps address/data stable with the strobe released.
         sram_we_n  <= !(nxt_wr && nxt_cnt != 4'(WAIT_CYCLES));
         if (state == RD_LO && last) lo <= sram_dq_in;
         if (state == RD_HI && last) read_data <= {sram_dq_in, lo};
      end
   end
endmodule

// File: doc/sram_word_controller.md
Name: sram_word_controller

Overview:
- Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM.
- Splits each 32-bit word access into two 16-bit half accesses and sequences the SRAM strobes.
- Drives `ready`. The pipeline top derives `memFreeze = ~ready`, which stalls the ID, EXE and MEM stage registers until the access completes.

Parameters:
- ADDR_W, 18, SRAM half-word address width.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.
- WAIT_CYCLES, 1, extra cycles per half access (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- wr_en  in  1  MEM-stage store request (MEM_W_EN).
- rd_en  in  1  MEM-stage load request (MEM_R_EN).
- address  in  32  CPU byte address (ALU result).
- write_data  in  32  store value (Val_Rm).
- read_data  out  32  load result.
- ready  out  1  1 = no access pending or access complete this cycle.
- sram_addr  out  ADDR_W  SRAM half-word address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_in  in  16  data returned from SRAM.
- sram_dq_oe  out  1  1 = controller drives the DQ bus.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset, asynchronous while rst=0:
  - state=IDLE, counter=0, read_data=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - ready=1 once rst=1 and no request is present.
- Reset asserted mid-access: abort immediately to the reset values above. No partial write completes after the reset edge.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, 32-bit subtraction, truncated to ADDR_W-1 bits (wraps silently).
  - Low half: sram_addr = {word, 1'b0}, carries bits [15:0].
  - High half: sram_addr = {word, 1'b1}, carries bits [31:16].
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
  - IDLE:
    - wr_en=1 -> WR_LO. wr_en has priority when both wr_en and rd_en are 1; rd_en is ignored.
    - else rd_en=1 -> RD_LO.
    - else stay in IDLE.
    - Address and write_data are sampled on this edge into internal registers.
  - Half states: each lasts exactly WAIT_CYCLES+1 cycles, using a counter that counts 0..WAIT_CYCLES and clears on every state change.
    - WR_LO -> WR_HI -> DONE.
    - RD_LO -> RD_HI -> DONE.
  - DONE: one cycle, then -> IDLE unconditionally. Requests are not sampled in DONE.
- ready is combinational: ready = (state==IDLE && !wr_en && !rd_en) || state==DONE.
  - A request entering in IDLE sees ready=0 in that same cycle.
  - ready stays 0 for exactly 2*(WAIT_CYCLES+1)+1 cycles.
  - ready is 1 in the DONE cycle.
- Write halves:
  - sram_dq_oe=1 for every cycle of WR_LO and WR_HI; sram_dq_out = the selected 16-bit half.
  - sram_we_n=0 in every cycle of a write half except its final cycle (counter==WAIT_CYCLES).
  - That final cycle holds address and data stable with we_n=1.
- Read halves:
  - sram_dq_oe=0, sram_we_n=1.
  - sram_dq_in is sampled on the edge that ends the half: RD_LO into lo[15:0], RD_HI into read_data.
  - read_data = {dq_in, lo}, valid from the DONE cycle onward.
  - read_data holds its value until the next read completes; writes do not modify it.
- IDLE and DONE outputs: sram_we_n=1, sram_dq_oe=0. sram_addr holds its last value.
- Back-to-back requests: the request present in the IDLE cycle after DONE starts a new access. There is no request queueing.

Test Plan:
- Reset with rst=0 mid-WR_LO, WAIT_CYCLES=1 -> outputs return to reset values in the same cycle; after release, ready=1 and sram_we_n=1.
- Store of 0xDEADBEEF to address 1024+8, WAIT_CYCLES=1:
  - ready=0 for 5 cycles, then ready=1 for 1 cycle.
  - sram_addr 4 with data 0xBEEF, we_n pattern 0,1.
  - Then sram_addr 5 with data 0xDEAD, we_n pattern 0,1.
- Load from the same address, model returns the stored data -> read_data=0xDEADBEEF in the DONE cycle; sram_dq_oe=0 throughout.
- wr_en=1 and rd_en=1 together -> write sequence only; read_data unchanged from its prior value.
- WAIT_CYCLES=3 -> ready low for 9 cycles; each half lasts 4 cycles with we_n=0,0,0,1.
- Address 1020 (word -1) -> sram_addr wraps to {ADDR_W-1 ones, 0} for the low half; no hang, ready returns to 1.
